// File: rtl/digit_window_scroller.sv
// digit_window_scroller: holds a double-buffered window of NDIG consecutive
// digits starting at a scrolling base index. Digits are pulled one at a time
// from an external source, and the visible window is replaced in a single
// cycle once every digit of the new window has arrived.
//
// Handshake (fetch_req/fetch_ack): a digit is transferred on any cycle where
// fetch_req && fetch_ack. While fetch_req is high, fetch_idx is held until
// that transfer happens. fetch_digit is sampled only on the transfer cycle.
// The source may wait any number of cycles before acknowledging.
module digit_window_scroller #(
  parameter int NDIG       = 8,
  parameter int IDX_W      = 24,
  parameter int MAXN       = 66346,
  parameter int SCROLL_DIV = 33554432
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  output logic                 fetch_req,
  output logic [IDX_W-1:0]     fetch_idx,
  input  logic                 fetch_ack,
  input  logic [3:0]           fetch_digit,
  output logic [4*NDIG-1:0]    digits,
  output logic [IDX_W-1:0]     base,
  output logic                 busy,
  output logic                 frame_valid
);

  localparam int TW = $clog2(SCROLL_DIV);
  localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [TW-1:0]    TIMER_LAST = TW'(SCROLL_DIV - 1);
  localparam logic [SW-1:0]    SLOT_LAST  = SW'(NDIG - 1);
  localparam logic [IDX_W-1:0] MAXN_V     = IDX_W'(MAXN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [TW-1:0]       timer;
  logic                pending;
  logic                reload;
  logic [SW-1:0]       slot;
  logic [IDX_W-1:0]    work_base;
  logic [IDX_W-1:0]    next_base;
  logic [4*NDIG-1:0]   shadow;
  logic                expire;
  logic                xfer;
  logic                take_reload;
  logic                take_step;

  // A timer expiry happens on the cycle the running timer sits at its last value.
  assign expire    = run && (timer == TIMER_LAST);
  assign xfer      = (state == FETCH) && fetch_ack;
  assign next_base = (base == MAXN_V) ? '0 : base + IDX_W'(1);
  assign fetch_idx = work_base + IDX_W'(slot);
  assign busy      = (state != IDLE);

  // Next-state and handshake outputs; reload wins over a pending advance.
  always_comb begin
    state_next  = state;
    take_reload = 1'b0;
    take_step   = 1'b0;
    fetch_req   = 1'b0;
    frame_valid = 1'b0;
    case (state)
      IDLE: begin
        if (reload) begin
          take_reload = 1'b1;
          state_next  = FETCH;
        end else if (pending) begin
          take_step  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack && (slot == SLOT_LAST)) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        frame_valid = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Scroll timer and single-entry advance request; events arriving while a
  // request is already outstanding (or being consumed) are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      pending <= 1'b0;
    end else begin
      if (run) begin
        timer <= expire ? '0 : timer + TW'(1);
      end
      if (take_step) begin
        pending <= 1'b0;
      end else if (step || expire) begin
        pending <= 1'b1;
      end
    end
  end

  // Working window: chooses the base to fetch and collects digits into shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload    <= 1'b1;
      slot      <= '0;
      work_base <= '0;
      shadow    <= '0;
    end else begin
      if (take_reload) begin
        reload    <= 1'b0;
        work_base <= base;
        slot      <= '0;
      end else if (take_step) begin
        work_base <= next_base;
        slot      <= '0;
      end else if (xfer) begin
        shadow[{slot, 2'b00} +: 4] <= fetch_digit;
        if (slot != SLOT_LAST) begin
          slot <= slot + SW'(1);
        end
      end
    end
  end

  // Committed window: replaced in one cycle so the display never sees a mix.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= '0;
      base   <= '0;
    end else if (state == COMMIT) begin
      digits <= shadow;
      base   <= work_base;
    end
  end

endmodule

// File: tb/tb_digit_window_scroller.sv
// Testbench for digit_window_scroller: a digit source returning idx[3:0],
// a negedge monitor that scores every committed window against a model of
// expected bases, and directed/randomized scenarios driven from one initial.
module tb_digit_window_scroller;

  localparam int NDIG       = 8;
  localparam int IDX_W      = 24;
  localparam int MAXN       = 10;
  localparam int SCROLL_DIV = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                run = 1'b0;
  logic                step = 1'b0;
  logic                fetch_req;
  logic [IDX_W-1:0]    fetch_idx;
  logic                fetch_ack = 1'b0;
  logic [3:0]          fetch_digit = 4'd0;
  logic [4*NDIG-1:0]   digits;
  logic [IDX_W-1:0]    base;
  logic                busy;
  logic                frame_valid;

  digit_window_scroller #(
    .NDIG(NDIG), .IDX_W(IDX_W), .MAXN(MAXN), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .fetch_req(fetch_req), .fetch_idx(fetch_idx), .fetch_ack(fetch_ack),
    .fetch_digit(fetch_digit), .digits(digits), .base(base),
    .busy(busy), .frame_valid(frame_valid)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: window contents and base progression from the rules.
  function automatic logic [31:0] model_window(input int b);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < NDIG; k++) w[4*k +: 4] = 4'((b + k) % 16);
    return w;
  endfunction

  function automatic int model_next(input int b);
    return (b == MAXN) ? 0 : b + 1;
  endfunction

  // Scoreboard state.
  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] xfer_q[$];
  int               fv_times[$];
  int               cyc = 0;
  int               frames = 0;
  int               stab_err = 0;
  int               ack_mode = 0;
  int               model_base = 0;
  bit               chk_next = 0;
  logic [IDX_W-1:0] chk_base;
  logic             prev_hold = 1'b0;
  logic [IDX_W-1:0] prev_idx = '0;
  logic [31:0]      last_digits = '0;
  logic [IDX_W-1:0] last_base = '0;

  // Monitor + source driver, all at negedge.
  always @(negedge clk) begin
    logic a;
    cyc++;
    if (rst) begin
      xfer_q.delete();
      exp_q.delete();
      chk_next    = 0;
      prev_hold   = 1'b0;
      last_digits = '0;
      last_base   = '0;
    end else begin
      if (chk_next) begin
        check("commit_base", 32'(base), 32'(chk_base));
        check("commit_digits", digits, model_window(int'(chk_base)));
        last_digits = digits;
        last_base   = base;
        chk_next    = 0;
      end else if (digits !== last_digits || base !== last_base) begin
        stab_err++;
      end
      if (prev_hold && (!fetch_req || fetch_idx !== prev_idx)) stab_err++;
      if (frame_valid) begin
        frames++;
        fv_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          chk_base = exp_q.pop_front();
          chk_next = 1;
          check("xfer_count", 32'(xfer_q.size()), 32'(NDIG));
          for (int k = 0; k < NDIG && k < xfer_q.size(); k++)
            check("xfer_idx", 32'(xfer_q[k]), 32'(IDX_W'(int'(chk_base) + k)));
        end
        xfer_q.delete();
      end
    end
    case (ack_mode)
      0:       a = 1'b1;
      1:       a = (cyc % 3 == 0);
      default: a = 1'($urandom_range(0, 1));
    endcase
    fetch_ack   = a;
    fetch_digit = a ? fetch_idx[3:0] : 4'($urandom_range(0, 15));
    if (!rst) begin
      prev_hold = fetch_req && !a;
      prev_idx  = fetch_idx;
      if (fetch_req && a) xfer_q.push_back(fetch_idx);
    end
  end

  // Driver tasks.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_step();
    model_base = model_next(model_base);
    exp_q.push_back(IDX_W'(model_base));
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      tick(1);
      n++;
    end
    check("frame_wait", 32'(frames >= target), 32'd1);
  endtask

  int f0;
  bit found;

  initial begin
    // Reset state.
    tick(3);
    check("rst_digits", digits, 32'h0);
    check("rst_base", 32'(base), 32'h0);
    check("rst_req", 32'(fetch_req), 32'h0);
    check("rst_idx", 32'(fetch_idx), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);

    // Initial fill with ack tied high: exact timing.
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      if (i == 1) exp_q.push_back('0);
      if (i <= 8) begin
        check("t1_req", 32'(fetch_req), 32'd1);
        check("t1_idx", 32'(fetch_idx), 32'(i - 1));
        check("t1_fv_low", 32'(frame_valid), 32'd0);
      end else begin
        check("t1_fv", 32'(frame_valid), 32'd1);
      end
    end
    tick(1);
    check("t1_digits", digits, 32'h76543210);
    check("t1_base", 32'(base), 32'd0);
    model_base = 0;

    // Single step with run=0.
    tick(3);
    f0 = frames;
    do_step();
    wait_frames(f0 + 1, 60);
    tick(20);
    check("t2_frames", 32'(frames - f0), 32'd1);
    check("t2_digits", digits, 32'h87654321);
    check("t2_base", 32'(base), 32'd1);

    // Slow source: ack every third cycle.
    ack_mode = 1;
    f0 = frames;
    do_step();
    wait_frames(f0 + 1, 200);
    tick(30);
    check("t3_frames", 32'(frames - f0), 32'd1);

    // Random ack pattern and random gaps, stepping until the base wraps.
    ack_mode = 2;
    do begin
      tick($urandom_range(0, 5));
      f0 = frames;
      do_step();
      wait_frames(f0 + 1, 300);
    end while (model_base != 0);
    tick(3);
    check("t4_wrap_base", 32'(base), 32'd0);

    // Pending saturation: three steps during one fetch give one more advance.
    ack_mode = 1;
    tick(2);
    f0 = frames;
    do_step();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (busy) found = 1;
    end
    check("t5_busy_seen", 32'(found), 32'd1);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(1);
    end
    check("t5_still_busy", 32'(busy), 32'd1);
    model_base = model_next(model_base);
    exp_q.push_back(IDX_W'(model_base));
    wait_frames(f0 + 2, 400);
    tick(60);
    check("t5_frames", 32'(frames - f0), 32'd2);

    // Automatic scrolling at SCROLL_DIV=16.
    ack_mode = 0;
    tick(5);
    fv_times.delete();
    f0 = frames;
    for (int i = 0; i < 4; i++) begin
      model_base = model_next(model_base);
      exp_q.push_back(IDX_W'(model_base));
    end
    run = 1'b1;
    tick(70);
    run = 1'b0;
    tick(40);
    check("t6_frames", 32'(frames - f0), 32'd4);
    check("t6_times", 32'(fv_times.size()), 32'd4);
    for (int i = 1; i < 4 && i < fv_times.size(); i++)
      check("t6_gap", 32'(fv_times[i] - fv_times[i-1]), 32'd16);

    // Timer holds while run=0: 9 more counts reach the last value, no expiry.
    f0 = frames;
    run = 1'b1;
    tick(9);
    run = 1'b0;
    tick(30);
    check("t6_hold", 32'(frames - f0), 32'd0);
    model_base = model_next(model_base);
    exp_q.push_back(IDX_W'(model_base));
    run = 1'b1;
    tick(1);
    run = 1'b0;
    wait_frames(f0 + 1, 40);
    tick(3);
    check("t6_resume_base", 32'(base), 32'(model_base));

    // Reset in the middle of a fetch.
    tick(3);
    do_step();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (fetch_req && fetch_idx == IDX_W'(model_base + 4)) found = 1;
    end
    check("t7_slot4_found", 32'(found), 32'd1);
    rst = 1'b1;
    tick(1);
    check("t7_req", 32'(fetch_req), 32'd0);
    check("t7_digits", digits, 32'h0);
    check("t7_base", 32'(base), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    model_base = 0;
    exp_q.push_back('0);
    f0 = frames;
    wait_frames(f0 + 1, 40);
    tick(3);
    check("t7_reload_digits", digits, 32'h76543210);
    check("t7_reload_base", 32'(base), 32'd0);

    // Final report.
    tick(5);
    check("stability", 32'(stab_err), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/digit_window_scroller.md
Name: digit_window_scroller

Overview:
Parametrised successor to the fixed 8-digit pi scroller. Keeps a window of NDIG consecutive digits starting at a scrolling base index. The digits come from an external digit source, such as pi_get_digit or a wrapper around it, over a req/ack handshake that tolerates variable latency. The window is double-buffered, so the display driver (display8 or wider) only ever sees a complete, untorn window. Scrolling is free-running at a programmable rate or single-stepped, and the base wraps at MAXN.

Parameters:
NDIG, 8, number of digits in the window (1..16)
IDX_W, 24, width of digit index / base
MAXN, 66346, last legal base value; base wraps to 0 after it
SCROLL_DIV, 33554432, clk cycles per automatic step while run=1 (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
run  in  1  level; enables automatic scrolling
step  in  1  single-cycle pulse; requests one advance
fetch_req  out  1  digit request to source
fetch_idx  out  IDX_W  requested digit index; stable while fetch_req=1
fetch_ack  in  1  source handshake; transfer occurs on a cycle where fetch_req&&fetch_ack
fetch_digit  in  4  digit value; sampled only on transfer
digits  out  4*NDIG  committed window; digits[4k+:4] = digit at base+k
base  out  IDX_W  base index of committed window
busy  out  1  high while in FETCH or COMMIT
frame_valid  out  1  one-cycle pulse when a new window is committed

Behaviour:
- Reset values: digits=0, base=0, fetch_req=0, fetch_idx=0, busy=0, frame_valid=0, timer=0, pending=0, reload=1, state=IDLE. Reset mid-fetch aborts it; fetch_req is low in the cycle after rst is sampled.
- Timer:
  - Counts clk cycles while run=1; holds its value while run=0.
  - At SCROLL_DIV-1 it wraps to 0 and sets pending.
  - A step pulse also sets pending.
  - pending saturates at 1. Extra steps or timer expiries while pending=1 are dropped, including those during FETCH/COMMIT.
- State machine (IDLE, FETCH, COMMIT):
  - IDLE with reload=1: clear reload, keep base, slot=0, go to FETCH. Reload takes priority over pending, and pending is kept.
  - IDLE with pending=1: clear pending. next_base = (base==MAXN) ? 0 : base+1. Load the working base with next_base, slot=0, go to FETCH.
  - Committed base output updates only at COMMIT.
  - FETCH: fetch_req=1, fetch_idx=work_base+slot, truncated to IDX_W.
    - On transfer: shadow[slot] <= fetch_digit.
    - If slot==NDIG-1, go to COMMIT; otherwise slot+1, and fetch_req stays high with the new idx in the next cycle.
    - No ack means hold req and idx unchanged indefinitely; there is no timeout.
  - COMMIT: fetch_req=0, digits<=shadow, base<=work_base, frame_valid=1 for this one cycle, go to IDLE.
- Latency: with fetch_ack tied high, IDLE-to-frame_valid is NDIG+1 cycles (1 IDLE decision + NDIG FETCH + COMMIT cycle = frame_valid). Throughput is one digit per cycle.
- Atomicity:
  - digits and base change only in the COMMIT cycle.
  - Between commits they are stable regardless of source stalls.
- fetch_digit values >9 are passed through unmodified.
- Indices base+k above MAXN are still requested (digits beyond MAXN+NDIG-1 are the source's concern).

Test Plan:
- Reset release, fetch_ack=1, source returns idx[3:0]:
  - fetch_idx 0..7 on consecutive cycles.
  - frame_valid at cycle 9 after reset release.
  - digits=32'h76543210, base=0.
- One step pulse after initial fill, run=0:
  - fetch_idx 1..8.
  - Then base=1, digits=32'h87654321, exactly one frame_valid.
- Source acks only every 3rd cycle:
  - fetch_idx stays constant between acks.
  - digits/base unchanged until COMMIT.
  - 8 transfers, 1 frame_valid.
- SCROLL_DIV=16, run=1, ack=1:
  - frame_valid every 16 cycles.
  - base increments 1,2,3...
  - run=0 stops increments and holds the timer.
- Wrap and pending saturation:
  - Force base to MAXN via steps with MAXN=10, then step: base becomes 0, with fetches idx 0..7.
  - Three step pulses during one FETCH produce exactly one further advance.
- Mid-fetch reset:
  - Assert rst during slot 4 of FETCH; next cycle fetch_req=0, digits=0, base=0.
  - After release, a clean reload from idx 0 completes.
